// File: rtl/tile_sched_pkg.sv
// tile_sched_pkg
// Shared types for the tile scheduler: per-tile state encoding, the queued
// job descriptor, and a round-robin "first requester at or after ptr" picker
// used by both the dispatch and completion arbiters.
package tile_sched_pkg;

  localparam int JOB_ID_W = 4;
  localparam int RR_MAX   = 32;
  localparam int RR_W     = 5;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    RUN     = 3'd2,
    DRAIN   = 3'd3,
    RELEASE = 3'd4
  } tile_state_e;

  typedef struct packed {
    logic [JOB_ID_W-1:0] id;
    logic                mode;
  } job_t;

  // Returns the index of the first set bit of req[n-1:0] found searching
  // upward from ptr (wrapping), or -1 when nothing is requested. Scanning the
  // offsets from high to low lets the smallest offset overwrite the result.
  function automatic int rr_first(input logic [RR_MAX-1:0] req,
                                  input int ptr, input int n);
    int idx;
    rr_first = -1;
    for (int k = n - 1; k >= 0; k--) begin
      idx = (ptr + k) % n;
      if (req[idx[RR_W-1:0]]) rr_first = idx;
    end
  endfunction

endpackage

// File: rtl/job_fifo.sv
// job_fifo
// Synchronous FIFO of job descriptors. Pushes while full and pops while
// empty are ignored. Read data is the head entry, valid whenever !empty_o.
// Ports:
//   clk, reset        clock, synchronous active-high reset (empties queue)
//   push_i, wdata_i   enqueue request and descriptor
//   pop_i             dequeue the head entry
//   rdata_o           head entry
//   full_o, empty_o   occupancy flags
module job_fifo
  import tile_sched_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic push_i,
  input  job_t wdata_i,
  input  logic pop_i,
  output job_t rdata_o,
  output logic full_o,
  output logic empty_o
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty.
  logic [AW:0] wr_q, rd_q;
  job_t        mem_q [DEPTH];

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign rdata_o = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i && !full_o) begin
        mem_q[wr_q[AW-1:0]] <= wdata_i;
        wr_q                <= wr_q + 1'b1;
      end
      if (pop_i && !empty_o) begin
        rd_q <= rd_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tile_scheduler.sv
// tile_scheduler
// Queues PE job descriptors and dispatches them round-robin to idle tiles,
// tracks each tile through its job, and funnels tile completions through a
// single registered completion slot.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   job_valid/job_ready         job descriptor handshake (job_id, job_mode)
//   tile_idle, tile_done        per-tile im2col idle / result-ready inputs
//   tile_start                  per-tile start pulse
//   tile_mode                   per-tile PE mode while the job is held
//   tile_output_taken           per-tile release pulse
//   cmp_valid/cmp_ready         completion handshake (cmp_id, cmp_tile)
//   busy                        queue non-empty or any tile not IDLE
//
// Per-tile FSM:
//   state   | meaning
//   IDLE    | free; may receive a dispatch when tile_idle is high
//   START   | tile_start pulse, job id/mode latched
//   RUN     | waiting for tile_done
//   DRAIN   | result ready, waiting for completion handshake
//   RELEASE | tile_output_taken pulse
module tile_scheduler
  import tile_sched_pkg::*;
#(
  parameter int tile      = 4,
  parameter int JOB_DEPTH = 8,
  parameter int ID_WIDTH  = JOB_ID_W,
  parameter int TILE_W    = $clog2(tile)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                job_valid,
  output logic                job_ready,
  input  logic [ID_WIDTH-1:0] job_id,
  input  logic                job_mode,
  input  logic [tile-1:0]     tile_idle,
  input  logic [tile-1:0]     tile_done,
  output logic [tile-1:0]     tile_start,
  output logic [tile-1:0]     tile_mode,
  output logic [tile-1:0]     tile_output_taken,
  output logic                cmp_valid,
  input  logic                cmp_ready,
  output logic [ID_WIDTH-1:0] cmp_id,
  output logic [TILE_W-1:0]   cmp_tile,
  output logic                busy
);

  function automatic logic [TILE_W-1:0] ptr_inc(input logic [TILE_W-1:0] p);
    return (p == TILE_W'(tile - 1)) ? '0 : p + TILE_W'(1);
  endfunction

  job_t                push_job, head_job;
  logic                fifo_full, fifo_empty;

  logic [tile-1:0]     st_idle, st_drain;
  logic [ID_WIDTH-1:0] run_id [tile];

  logic [TILE_W-1:0]   disp_ptr_q, disp_ptr_d;
  logic [RR_MAX-1:0]   disp_req;
  int                  disp_pick;
  logic                disp_fire;
  logic [TILE_W-1:0]   disp_idx;

  logic                cmp_valid_q, cmp_valid_d;
  logic [ID_WIDTH-1:0] cmp_id_q, cmp_id_d;
  logic [TILE_W-1:0]   cmp_tile_q, cmp_tile_d;
  logic [TILE_W-1:0]   cmp_ptr_q, cmp_ptr_d;
  logic [RR_MAX-1:0]   cmp_req;
  int                  cmp_pick;
  logic                cmp_fire;

  assign push_job  = '{id: job_id, mode: job_mode};
  assign job_ready = !fifo_full;

  job_fifo #(.DEPTH(JOB_DEPTH)) u_job_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (job_valid),
    .wdata_i (push_job),
    .pop_i   (disp_fire),
    .rdata_o (head_job),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Dispatch arbiter: head of queue to the next eligible tile from disp_ptr.
  always_comb begin
    disp_req             = '0;
    disp_req[tile-1:0]   = st_idle & tile_idle;
    disp_pick            = rr_first(disp_req, int'(disp_ptr_q), tile);
    disp_fire            = !fifo_empty && (disp_pick >= 0);
    disp_idx             = disp_pick[TILE_W-1:0];
    disp_ptr_d           = disp_ptr_q;
    if (disp_fire) disp_ptr_d = ptr_inc(disp_idx);
  end

  // Completion slot. The tile currently held in the slot stays in DRAIN until
  // its handshake, so it is masked out to avoid reporting it twice. On an
  // accepting cycle the search already starts past the tile being accepted,
  // which keeps back-to-back completions at one per cycle.
  always_comb begin
    cmp_fire = cmp_valid_q && cmp_ready;
    cmp_req  = '0;
    for (int t = 0; t < tile; t++) begin
      cmp_req[t] = st_drain[t] && !(cmp_valid_q && (cmp_tile_q == TILE_W'(t)));
    end
    cmp_ptr_d   = cmp_fire ? ptr_inc(cmp_tile_q) : cmp_ptr_q;
    cmp_pick    = rr_first(cmp_req, int'(cmp_ptr_d), tile);
    cmp_valid_d = cmp_valid_q;
    cmp_id_d    = cmp_id_q;
    cmp_tile_d  = cmp_tile_q;
    if (!cmp_valid_q || cmp_ready) begin
      cmp_valid_d = (cmp_pick >= 0);
      if (cmp_pick >= 0) begin
        cmp_tile_d = cmp_pick[TILE_W-1:0];
        cmp_id_d   = run_id[cmp_pick[TILE_W-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      disp_ptr_q  <= '0;
      cmp_ptr_q   <= '0;
      cmp_valid_q <= 1'b0;
      cmp_id_q    <= '0;
      cmp_tile_q  <= '0;
    end else begin
      disp_ptr_q  <= disp_ptr_d;
      cmp_ptr_q   <= cmp_ptr_d;
      cmp_valid_q <= cmp_valid_d;
      cmp_id_q    <= cmp_id_d;
      cmp_tile_q  <= cmp_tile_d;
    end
  end

  for (genvar g = 0; g < tile; g++) begin : g_tile
    tile_state_e state_q, state_d;
    job_t        job_q;
    logic        disp_here;

    assign disp_here = disp_fire && (disp_idx == TILE_W'(g));

    always_comb begin
      state_d = state_q;
      unique case (state_q)
        IDLE:    if (disp_here) state_d = START;
        START:   state_d = RUN;
        RUN:     if (tile_done[g]) state_d = DRAIN;
        DRAIN:   if (cmp_fire && (cmp_tile_q == TILE_W'(g))) state_d = RELEASE;
        RELEASE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= IDLE;
        job_q   <= '0;
      end else begin
        state_q <= state_d;
        if (disp_here) job_q <= head_job;
      end
    end

    assign st_idle[g]           = (state_q == IDLE);
    assign st_drain[g]          = (state_q == DRAIN);
    assign tile_start[g]        = (state_q == START);
    assign tile_output_taken[g] = (state_q == RELEASE);
    assign tile_mode[g]         = ((state_q == START) || (state_q == RUN) ||
                                   (state_q == DRAIN)) ? job_q.mode : 1'b0;
    assign run_id[g]            = job_q.id;
  end

  assign cmp_valid = cmp_valid_q;
  assign cmp_id    = cmp_id_q;
  assign cmp_tile  = cmp_tile_q;
  assign busy      = !fifo_empty || (st_idle != '1);

endmodule

// File: tb/tb_tile_scheduler.sv
module tb_tile_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       job_valid = 1'b0;
  logic       job_ready;
  logic [3:0] job_id = '0;
  logic       job_mode = 1'b0;
  logic [3:0] tile_idle = '1;
  logic [3:0] tile_done;
  logic [3:0] tile_start, tile_mode, tile_output_taken;
  logic       cmp_valid;
  logic       cmp_ready = 1'b0;
  logic [3:0] cmp_id;
  logic [1:0] cmp_tile;
  logic       busy;

  logic [3:0] man_done  = '0;
  logic [3:0] auto_done = '0;
  logic       auto_en   = 1'b0;
  int         cnt [4];

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0] id;
    logic [1:0] tile;
  } exp_t;
  exp_t sb [$];

  assign tile_done = man_done | auto_done;

  always #5 clk = ~clk;

  tile_scheduler dut (
    .clk               (clk),
    .reset             (reset),
    .job_valid         (job_valid),
    .job_ready         (job_ready),
    .job_id            (job_id),
    .job_mode          (job_mode),
    .tile_idle         (tile_idle),
    .tile_done         (tile_done),
    .tile_start        (tile_start),
    .tile_mode         (tile_mode),
    .tile_output_taken (tile_output_taken),
    .cmp_valid         (cmp_valid),
    .cmp_ready         (cmp_ready),
    .cmp_id            (cmp_id),
    .cmp_tile          (cmp_tile),
    .busy              (busy)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    job_valid = 1'b0;
    man_done  = '0;
    auto_en   = 1'b0;
    cmp_ready = 1'b0;
    tile_idle = '1;
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic wait_sb_empty(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
    chk("sb_drain", sb.size(), 0);
  endtask

  // Scoreboard: every accepted completion must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && cmp_valid && cmp_ready) begin
      if (sb.size() == 0) begin
        chk("cmp_extra", int'(cmp_valid), 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("cmp_id", int'(cmp_id), int'(e.id));
        chk("cmp_tile", int'(cmp_tile), int'(e.tile));
      end
    end
  end

  // Tile model: raise tile_done in the first RUN cycle after tile_start.
  always begin
    @(negedge clk);
    for (int t = 0; t < 4; t++) if (auto_en && tile_start[t]) cnt[t] = 1;
    @(posedge clk);
    #1;
    for (int t = 0; t < 4; t++) begin
      auto_done[t] = 1'b0;
      if (cnt[t] > 0) begin
        cnt[t]--;
        if (cnt[t] == 0) auto_done[t] = 1'b1;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_start [10];
    exp_start = '{0, 0, 1, 2, 4, 8, 0, 0, 1, 0};

    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst_job_ready", int'(job_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_start", int'(tile_start), 0);
    chk("rst_taken", int'(tile_output_taken), 0);
    chk("rst_mode", int'(tile_mode), 0);
    chk("rst_cmp_valid", int'(cmp_valid), 0);
    chk("rst_cmp_id", int'(cmp_id), 0);
    chk("rst_cmp_tile", int'(cmp_tile), 0);

    // Single job id=3 mode=1
    next_cycle();
    job_valid = 1'b1; job_id = 4'd3; job_mode = 1'b1;
    sb.push_back('{id: 4'd3, tile: 2'd0});
    @(negedge clk); chk("t1_ready", int'(job_ready), 1);
    next_cycle(); job_valid = 1'b0;
    @(negedge clk); chk("t1_start_early", int'(tile_start), 0);
    next_cycle();
    @(negedge clk);
    chk("t1_start", int'(tile_start), 1);
    chk("t1_mode", int'(tile_mode), 1);
    next_cycle(); man_done = 4'b0001;
    @(negedge clk); chk("t1_start_pulse", int'(tile_start), 0);
    next_cycle(); man_done = '0;
    @(negedge clk); chk("t1_cmp_early", int'(cmp_valid), 0);
    next_cycle(); cmp_ready = 1'b1;
    @(negedge clk); chk("t1_cmp_valid", int'(cmp_valid), 1);
    next_cycle(); cmp_ready = 1'b0;
    @(negedge clk);
    chk("t1_taken", int'(tile_output_taken), 1);
    chk("t1_cmp_clear", int'(cmp_valid), 0);
    next_cycle();
    @(negedge clk);
    chk("t1_taken_pulse", int'(tile_output_taken), 0);
    chk("t1_busy", int'(busy), 0);

    // Four back-to-back jobs plus a fifth waiting for the first release
    do_reset();
    auto_en = 1'b1; cmp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      if (i < 5) begin
        job_valid = 1'b1; job_id = 4'(i); job_mode = 1'b0;
        sb.push_back('{id: 4'(i), tile: 2'(i % 4)});
      end else begin
        job_valid = 1'b0;
      end
      @(negedge clk);
      chk($sformatf("t2_start_c%0d", i), int'(tile_start), exp_start[i]);
      if (i == 6) chk("t2_taken0", int'(tile_output_taken), 1);
    end
    wait_sb_empty(40);

    // Queue fill with no eligible tiles
    do_reset();
    tile_idle = '0; auto_en = 1'b1; cmp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      job_valid = 1'b1; job_id = 4'(i); job_mode = i[0];
      sb.push_back('{id: 4'(i), tile: 2'(i % 4)});
      @(negedge clk); chk($sformatf("t3_ready_%0d", i), int'(job_ready), 1);
    end
    next_cycle(); job_id = 4'd8;
    sb.push_back('{id: 4'd8, tile: 2'd0});
    @(negedge clk); chk("t3_full", int'(job_ready), 0);
    next_cycle();
    @(negedge clk);
    chk("t3_full_hold", int'(job_ready), 0);
    chk("t3_busy", int'(busy), 1);
    next_cycle(); tile_idle = '1;
    @(negedge clk); chk("t3_full_on_pop", int'(job_ready), 0);
    next_cycle();
    @(negedge clk); chk("t3_ready_after_pop", int'(job_ready), 1);
    next_cycle(); job_valid = 1'b0;
    wait_sb_empty(80);

    // tile_idle[0]=0 steers the job to tile 1; tile_done in IDLE is ignored
    do_reset();
    tile_idle = 4'b1110; auto_en = 1'b1; cmp_ready = 1'b1;
    next_cycle();
    job_valid = 1'b1; job_id = 4'd9; job_mode = 1'b0;
    sb.push_back('{id: 4'd9, tile: 2'd1});
    next_cycle(); job_valid = 1'b0;
    next_cycle();
    @(negedge clk); chk("t5_start_t1", int'(tile_start), 2);
    wait_sb_empty(20);
    auto_en = 1'b0;
    next_cycle(); next_cycle(); next_cycle();
    man_done = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      @(negedge clk);
      chk($sformatf("t5_idle_done_cmp_%0d", i), int'(cmp_valid), 0);
      chk($sformatf("t5_idle_done_busy_%0d", i), int'(busy), 0);
    end
    man_done = '0;

    // Simultaneous done on tiles 1 and 2 with back-pressure
    do_reset();
    tile_idle = 4'b0110;
    next_cycle();
    job_valid = 1'b1; job_id = 4'd5; job_mode = 1'b1;
    sb.push_back('{id: 4'd5, tile: 2'd1});
    next_cycle();
    job_id = 4'd6; job_mode = 1'b0;
    sb.push_back('{id: 4'd6, tile: 2'd2});
    next_cycle(); job_valid = 1'b0;
    next_cycle(); next_cycle();
    @(negedge clk); chk("t4_mode", int'(tile_mode), 2);
    next_cycle(); man_done = 4'b0111;
    @(negedge clk); chk("t4_cmp_none0", int'(cmp_valid), 0);
    next_cycle(); man_done = '0;
    @(negedge clk); chk("t4_cmp_none1", int'(cmp_valid), 0);
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      @(negedge clk);
      chk($sformatf("t4_hold_valid_%0d", i), int'(cmp_valid), 1);
      chk($sformatf("t4_hold_tile_%0d", i), int'(cmp_tile), 1);
      chk($sformatf("t4_hold_id_%0d", i), int'(cmp_id), 5);
    end
    next_cycle(); cmp_ready = 1'b1;
    @(negedge clk); chk("t4_accept_tile", int'(cmp_tile), 1);
    next_cycle();
    @(negedge clk);
    chk("t4_second_valid", int'(cmp_valid), 1);
    chk("t4_second_tile", int'(cmp_tile), 2);
    chk("t4_taken1", int'(tile_output_taken), 2);
    next_cycle(); cmp_ready = 1'b0;
    @(negedge clk);
    chk("t4_drained", int'(cmp_valid), 0);
    chk("t4_taken2", int'(tile_output_taken), 4);
    wait_sb_empty(5);

    // Reset with two tiles running and three jobs queued
    do_reset();
    tile_idle = 4'b0011; cmp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      job_valid = 1'b1; job_id = 4'(i + 10); job_mode = 1'b1;
    end
    next_cycle(); job_valid = 1'b0;
    next_cycle();
    @(negedge clk);
    chk("t6_pre_mode", int'(tile_mode), 3);
    chk("t6_pre_busy", int'(busy), 1);
    next_cycle(); reset = 1'b1;
    next_cycle(); reset = 1'b0;
    @(negedge clk);
    chk("t6_start", int'(tile_start), 0);
    chk("t6_taken", int'(tile_output_taken), 0);
    chk("t6_mode", int'(tile_mode), 0);
    chk("t6_cmp_valid", int'(cmp_valid), 0);
    chk("t6_cmp_id", int'(cmp_id), 0);
    chk("t6_cmp_tile", int'(cmp_tile), 0);
    chk("t6_busy", int'(busy), 0);
    chk("t6_job_ready", int'(job_ready), 1);
    man_done = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      @(negedge clk);
      chk($sformatf("t6_no_cmp_%0d", i), int'(cmp_valid), 0);
      chk($sformatf("t6_no_start_%0d", i), int'(tile_start), 0);
    end
    man_done = '0;
    chk("t6_sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
